// File: rtl/up_dn_counter_param.sv
// up_dn_counter_param
// Bounded up/down counter with a programmable range, a per-cycle step,
// a count enable, saturate or wrap behaviour at the limits, and a
// registered one-cycle Event pulse whenever a result is clipped or wrapped.
// High and Low are decoded directly from the registered count.

module up_dn_counter_param #(
   parameter int WIDTH   = 5,
   parameter int MIN_VAL = 0,
   parameter int MAX_VAL = 31,
   parameter int STEP_W  = 3,
   parameter int WRAP    = 0,
   parameter int RST_VAL = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WIDTH-1:0]  IN,
   input  logic              Load,
   input  logic              Up,
   input  logic              Down,
   input  logic              En,
   input  logic [STEP_W-1:0] Step,
   output logic [WIDTH-1:0]  Counter,
   output logic              High,
   output logic              Low,
   output logic              Event
);

   // Working width: wide enough that Counter+Step and Counter-Step never
   // overflow and the sign of an underflow is preserved.
   localparam int EW = WIDTH + STEP_W + 1;

   localparam logic signed [EW-1:0] MIN_S   = EW'(MIN_VAL);
   localparam logic signed [EW-1:0] MAX_S   = EW'(MAX_VAL);
   localparam logic signed [EW-1:0] RANGE_S = EW'(MAX_VAL - MIN_VAL + 1);

   logic signed [EW-1:0] cur_s;
   logic signed [EW-1:0] in_s;
   logic signed [EW-1:0] step_s;
   logic signed [EW-1:0] sum;
   logic [WIDTH-1:0]     nxt_cnt;
   logic                 nxt_ev;

   // Zero-extend the unsigned operands into the signed working width.
   assign cur_s  = $signed({{(STEP_W + 1){1'b0}}, Counter});
   assign in_s   = $signed({{(STEP_W + 1){1'b0}}, IN});
   assign step_s = $signed({{(WIDTH + 1){1'b0}}, Step});

   // Next count and boundary event: Load beats Down, Down beats Up.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      nxt_cnt = Counter;
      nxt_ev  = 1'b0;
      sum     = cur_s;
      if (Load) begin
         if (in_s < MIN_S) begin
            nxt_cnt = MIN_S[WIDTH-1:0];
            nxt_ev  = 1'b1;
         end else if (in_s > MAX_S) begin
            nxt_cnt = MAX_S[WIDTH-1:0];
            nxt_ev  = 1'b1;
         end else begin
            nxt_cnt = IN;
         end
      end else if (En && (Up || Down)) begin
         sum = Down ? (cur_s - step_s) : (cur_s + step_s);
         if (sum > MAX_S) begin
            nxt_ev = 1'b1;
            // Wrapped result lies in range, so modular low-bit arithmetic is exact.
            nxt_cnt = (WRAP != 0) ? (sum[WIDTH-1:0] - RANGE_S[WIDTH-1:0]) : MAX_S[WIDTH-1:0];
         end else if (sum < MIN_S) begin
            nxt_ev  = 1'b1;
            nxt_cnt = (WRAP != 0) ? (sum[WIDTH-1:0] + RANGE_S[WIDTH-1:0]) : MIN_S[WIDTH-1:0];
         end else begin
            nxt_cnt = sum[WIDTH-1:0];
         end
      end
   end

   // Count and event registers; reset discards any operation in flight.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         Counter <= WIDTH'(RST_VAL);
         Event   <= 1'b0;
      end else begin
         // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
         Counter <= nxt_cnt;
         Event   <= nxt_ev;
      end
   end

   assign High = (Counter == MAX_S[WIDTH-1:0]);
   assign Low  = (Counter == MIN_S[WIDTH-1:0]);

   // In wrap mode a step larger than the range would wrap more than once.
   step_in_range: assert property (@(posedge CLK) disable iff (!RST)
      !((WRAP != 0) && !Load && En && (Up || Down) && (step_s > RANGE_S)));

endmodule

// File: tb/tb_up_dn_counter_param.sv
// tb_up_dn_counter_param
// Two counters share one stimulus stream: a default saturating 0..31 part
// and a wrapping 3..20 part. A behavioural model tracks both; every cycle
// the outputs are compared against it, and directed scenarios pin literal
// values from hand calculation.

module tb_up_dn_counter_param;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [4:0] IN = '0;
   logic       Load = 1'b0;
   logic       Up = 1'b0;
   logic       Down = 1'b0;
   logic       En = 1'b0;
   logic [2:0] Step = '0;

   logic [4:0] cnt0, cnt1;
   logic       hi0, lo0, ev0, hi1, lo1, ev1;

   int n_checks = 0;
   int n_errors = 0;

   // Per-instance configuration seen by the model.
   int minv [2] = '{0, 3};
   int maxv [2] = '{31, 20};
   int wrapv[2] = '{0, 1};
   int rstv [2] = '{0, 3};

   int m_cnt[2];
   bit m_ev [2];

   up_dn_counter_param dut_sat (
      .CLK(CLK), .RST(RST), .IN(IN), .Load(Load), .Up(Up), .Down(Down),
      .En(En), .Step(Step), .Counter(cnt0), .High(hi0), .Low(lo0), .Event(ev0)
   );

   up_dn_counter_param #(
      .WIDTH(5), .MIN_VAL(3), .MAX_VAL(20), .STEP_W(3), .WRAP(1), .RST_VAL(3)
   ) dut_wrap (
      .CLK(CLK), .RST(RST), .IN(IN), .Load(Load), .Up(Up), .Down(Down),
      .En(En), .Step(Step), .Counter(cnt1), .High(hi1), .Low(lo1), .Event(ev1)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: plain integer arithmetic on the range rules.
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int k = 0; k < 2; k++) begin
            m_cnt[k] <= rstv[k];
            m_ev[k]  <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin : mdl
            int v;
            bit e;
            int n;
            v = m_cnt[k];
            e = 1'b0;
            n = maxv[k] - minv[k] + 1;
            if (Load) begin
               v = int'(IN);
               if (v < minv[k]) begin v = minv[k]; e = 1'b1; end
               else if (v > maxv[k]) begin v = maxv[k]; e = 1'b1; end
            end else if (En && (Up || Down) && Step != 0) begin
               v = Down ? v - int'(Step) : v + int'(Step);
               if (v > maxv[k]) begin
                  e = 1'b1;
                  v = wrapv[k] ? v - n : maxv[k];
               end else if (v < minv[k]) begin
                  e = 1'b1;
                  v = wrapv[k] ? v + n : minv[k];
               end
            end
            m_cnt[k] <= v;
            m_ev[k]  <= e;
         end
      end
   end

   // Per-cycle comparison away from the active edge.
   always @(negedge CLK) begin
      check("cnt_sat",  cnt0, m_cnt[0]);
      check("ev_sat",   ev0,  m_ev[0]);
      check("high_sat", hi0,  m_cnt[0] == maxv[0]);
      check("low_sat",  lo0,  m_cnt[0] == minv[0]);
      check("cnt_wrap", cnt1, m_cnt[1]);
      check("ev_wrap",  ev1,  m_ev[1]);
      check("high_wrap", hi1, m_cnt[1] == maxv[1]);
      check("low_wrap", lo1,  m_cnt[1] == minv[1]);
   end

   task automatic drive(input bit ld, input bit up, input bit dn, input bit en,
                        input int st, input int inv);
      @(negedge CLK);
      Load = ld;
      Up   = up;
      Down = dn;
      En   = en;
      Step = 3'(st);
      IN   = 5'(inv);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      #1;
      check("rst_cnt_sat",  cnt0, 0);
      check("rst_cnt_wrap", cnt1, 3);

      // Reset mid-count takes effect without a clock edge.
      drive(1, 0, 0, 0, 0, 17);
      tick();
      check("t1_pre", cnt0, 17);
      drive(0, 0, 0, 0, 0, 0);
      #2 RST = 1'b0;
      #1;
      check("t1_cnt",  cnt0, 0);
      check("t1_low",  lo0, 1);
      check("t1_high", hi0, 0);
      check("t1_ev",   ev0, 0);
      @(negedge CLK);
      RST = 1'b1;

      // Load then step up by 3.
      drive(1, 0, 0, 0, 0, 9);
      tick();
      check("t2_load", cnt0, 9);
      drive(0, 1, 0, 1, 3, 0);
      tick(); check("t2_c12", cnt0, 12); check("t2_e12", ev0, 0);
      tick(); check("t2_c15", cnt0, 15); check("t2_e15", ev0, 0);
      tick(); check("t2_c18", cnt0, 18); check("t2_e18", ev0, 0);

      // Saturation at MAX_VAL.
      drive(1, 0, 0, 0, 0, 29);
      tick();
      check("t3_load", cnt0, 29);
      drive(0, 1, 0, 1, 4, 0);
      tick(); check("t3_c31", cnt0, 31); check("t3_hi", hi0, 1); check("t3_ev", ev0, 1);
      tick(); check("t3_hold", cnt0, 31); check("t3_ev2", ev0, 1);
      drive(0, 0, 0, 0, 0, 0);
      tick(); check("t3_idle", cnt0, 31); check("t3_ev3", ev0, 0);

      // Wrap on the 3..20 instance.
      drive(1, 0, 0, 0, 0, 5);
      tick();
      check("t4_load", cnt1, 5);
      drive(0, 0, 1, 1, 4, 0);
      tick(); check("t4_dn", cnt1, 19); check("t4_ev_dn", ev1, 1);
      check("t4_model", m_cnt[1], 19);
      drive(0, 1, 0, 1, 2, 0);
      tick(); check("t4_up", cnt1, 3); check("t4_ev_up", ev1, 1); check("t4_low", lo1, 1);
      check("t4_model2", m_cnt[1], 3);

      // Down beats Up; Load beats Down and clamps.
      drive(1, 0, 0, 0, 0, 10);
      tick();
      drive(0, 1, 1, 1, 1, 0);
      tick(); check("t5_both", cnt1, 9); check("t5_both_sat", cnt0, 9);
      drive(1, 0, 1, 1, 1, 25);
      tick();
      check("t5_clamp", cnt1, 20); check("t5_clamp_ev", ev1, 1); check("t5_hi", hi1, 1);
      check("t5_noclamp", cnt0, 25); check("t5_noclamp_ev", ev0, 0);
      check("t5_model", m_cnt[1], 20);

      // Enable low and zero step both hold.
      drive(0, 1, 0, 0, 5, 0);
      for (int i = 0; i < 4; i++) begin
         tick(); check("t6_en0", cnt0, 25); check("t6_en0_ev", ev0, 0);
      end
      drive(0, 0, 1, 1, 0, 0);
      tick(); check("t6_step0", cnt0, 25); check("t6_step0_ev", ev0, 0);

      // Randomised traffic with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         Load = ($urandom_range(0, 9) == 0);
         Up   = 1'($urandom_range(0, 1));
         Down = ($urandom_range(0, 2) == 0);
         En   = ($urandom_range(0, 7) != 0);
         Step = 3'($urandom_range(0, 7));
         IN   = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 199) == 0) begin
            #2 RST = 1'b0;
            @(negedge CLK);
            RST = 1'b1;
         end
      end

      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge CLK);
      #1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/up_dn_counter_param.md
Name: up_dn_counter_param

Overview:
Parametrised successor to the team's 5-bit up/down counter. It adds configurable width, programmable count range [MIN_VAL, MAX_VAL], a per-cycle step size, and a count enable. It supports saturate or wrap mode and produces a registered one-cycle boundary-event pulse. Used wherever a bounded up/down count with limit flags is needed: level trackers, credit counters, position indices.

Parameters:
WIDTH, 5, counter width in bits
MIN_VAL, 0, lowest legal count value; must satisfy 0 <= MIN_VAL < MAX_VAL
MAX_VAL, 31, highest legal count value; must satisfy MAX_VAL <= 2^WIDTH-1
STEP_W, 3, width of the Step input
WRAP, 0, 0 = saturate at limits, 1 = wrap modulo range
RST_VAL, 0, Counter value after reset; must lie in [MIN_VAL, MAX_VAL]

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous assert, active-low
IN  input  WIDTH  load value
Load  input  1  synchronous load request
Up  input  1  count-up request
Down  input  1  count-down request
En  input  1  count enable; gates Up/Down only, not Load
Step  input  STEP_W  increment/decrement magnitude
Counter  output  WIDTH  registered count
High  output  1  combinational, Counter == MAX_VAL
Low  output  1  combinational, Counter == MIN_VAL
Event  output  1  registered one-cycle pulse on clip or wrap

Behaviour:
- Reset (RST=0, async): Counter=RST_VAL, Event=0. Reset deassertion is synchronised externally. Reset mid-count discards the operation in flight; no Event is produced.
- All state updates occur on the rising edge of CLK. The result of a request is visible on Counter one cycle after the request is sampled.
- Priority per cycle: Load > Down > Up > hold.
- Down has priority over Up when both are asserted. Up is effective only when Down=0.
- Load: Counter <= IN clamped to [MIN_VAL, MAX_VAL]. Event=1 only if clamping occurred. Load acts regardless of En.
- En=0, Step=0, or no request: Counter holds, Event=0.
- Arithmetic: compute at WIDTH+STEP_W+1 bits signed, range N = MAX_VAL-MIN_VAL+1.
- Up, WRAP=0: nxt = Counter+Step. If nxt > MAX_VAL, then Counter <= MAX_VAL and Event=1. Up while High=1 with Step>0 holds at MAX_VAL and pulses Event.
- Down, WRAP=0: nxt = Counter-Step. If nxt < MIN_VAL, then Counter <= MIN_VAL and Event=1. Down while Low=1 with Step>0 holds at MIN_VAL and pulses Event.
- Up, WRAP=1: if nxt > MAX_VAL, then Counter <= nxt-N and Event=1.
- Down, WRAP=1: if nxt < MIN_VAL, then Counter <= nxt+N and Event=1.
- Step > N is illegal in WRAP=1 mode; an assertion fires. In WRAP=0 mode it simply clips.
- Event is high for exactly one cycle per offending operation. Back-to-back offending operations keep Event high continuously.
- High and Low are decoded from the registered Counter and have no internal latency.
- No combinational path exists from any input to Counter or Event.

Test Plan:
1. Reset with RST=0 mid-count (Counter=17), defaults -> Counter=0, Low=1, High=0, Event=0 immediately, without waiting for a clock edge.
2. Defaults, Load=1, IN=9 -> Counter=9 next cycle. Then Up=1, En=1, Step=3 for 3 cycles -> 12, 15, 18 with Event=0 throughout.
3. Defaults, WRAP=0, Counter=29, Up=1, Step=4 -> Counter=31, High=1, Event=1 for one cycle. A further Up -> Counter stays 31, Event=1.
4. MIN_VAL=3, MAX_VAL=20, WRAP=1 (N=18), Counter=5, Down=1, Step=4 -> Counter=19, Event=1. Then Up=1, Step=2 -> Counter=3, Event=1.
5. Up=1 and Down=1 together, Step=1, Counter=10 -> Counter=9. Then Load=1, Down=1, IN=25 with MAX_VAL=20 -> Counter=20, Event=1.
6. En=0 with Up=1 and Step=5 -> Counter holds for 4 cycles, Event=0. Then Step=0 with En=1 and Down=1 -> Counter holds, Event=0.
